serial_adder_ctrl: RTL and testbench

//   Bit-serial sequencer for one shared full_adder cell. Adds two WIDTH-bit

---
 rtl/serial_adder_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder sequencer. A single full-adder cell is reused for WIDTH
//   cycles. Each cycle it adds one bit pair, LSB first, and the carry is kept
//   in a flop between cycles. The handshake is start/busy/done.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled only in IDLE or DONE
//   a, b      operands, captured when start is accepted
//   c_in      carry-in, captured when start is accepted
//   busy      high for the WIDTH cycles of RUN
//   done      one-cycle pulse marking sum/c_out valid
//   sum       result, held from done until the next accept
//   c_out     final carry, held with sum
//   overflow  two's-complement overflow, held with sum
//             (port exists only when SERIAL_ADDER_OVERFLOW_EN is defined)
//
// Build option
//   SERIAL_ADDER_OVERFLOW_EN  adds the overflow port and its flop.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one bit per cycle through the shared full adder
// DONE  | done pulse; start here is accepted back-to-back

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A WIDTH=1 build still needs a one-bit counter.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    // Shared full-adder cell. The new sum bit enters at the MSB, so after
    // WIDTH shifts the LSB-first bits sit in their final positions.
    always_comb begin
        fa_sum   = a_reg[0] ^ b_reg[0] ^ carry;
        fa_cout  = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
        sum_next = sum >> 1;
        sum_next[WIDTH-1] = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= c_in;
                        bit_cnt  <= '0;
                        sum      <= '0;
                        c_out    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        overflow <= 1'b0;
`endif
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= fa_cout;
                    sum     <= sum_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST) begin
                        c_out    <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // On the MSB cycle, carry holds the carry into the MSB.
                        overflow <= carry ^ fa_cout;
`endif
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Scoreboard bench for serial_adder_ctrl (WIDTH=8). Each expected result is
//   pushed when its stimulus is driven. It is popped and compared when done
//   pulses.

module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    int           n_done   = 0;
    int           busy_cnt = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference model. The overflow bit is the signed-add rule, which is
    // independent of the carry-chain formulation used in the design.
    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input int done_cyc);
        logic [W:0] r;
        exp_t       e;
        r      = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
        e.cyc  = done_cyc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check_eq("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("sum", 32'(sum), 32'(e.sum));
                    check_eq("c_out", 32'(c_out), 32'(e.cout));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    check_eq("overflow", 32'(overflow), 32'(e.ovf));
`endif
                    check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
                    check_eq("busy_len", 32'(busy_cnt), 32'(W));
                    last_sum  = e.sum;
                    last_cout = e.cout;
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive one request, then scramble the operands after acceptance.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        @(negedge clk);
        a = av; b = bv; c_in = ci; start = 1'b1;
        push_exp(av, bv, ci, cyc + 1 + W);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * W + 10 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clk);
        check_eq("sum_hold", 32'(sum), 32'(last_sum));
        check_eq("c_out_hold", 32'(c_out), 32'(last_cout));
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_c_out", 32'(c_out), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check_eq("rst_overflow", 32'(overflow), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h5A, 8'h3C, 1'b0); drain(); check_hold();
        run_op(8'hFF, 8'h01, 1'b0); drain(); check_hold();
        run_op(8'hFF, 8'h00, 1'b1); drain();
        run_op(8'h00, 8'h00, 1'b0); drain();
        run_op(8'hFF, 8'hFF, 1'b1); drain(); check_hold();
        run_op(8'h7F, 8'h01, 1'b0); drain();
        run_op(8'h80, 8'h80, 1'b0); drain();
        run_op(8'h05, 8'h03, 1'b0); drain();

        // A start pulse during RUN must be ignored.
        nd = n_done;
        run_op(8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (W + 3) @(negedge clk);
        check_eq("ignored_start_dones", 32'(n_done - nd), 32'd1);

        // Holding start high through DONE gives a back-to-back second operation.
        nd = n_done;
        @(negedge clk);
        a = 8'h11; b = 8'h22; c_in = 1'b0; start = 1'b1;
        push_exp(8'h11, 8'h22, 1'b0, cyc + 1 + W);
        push_exp(8'h10, 8'h20, 1'b0, cyc + 2 + 2 * W);
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        repeat (W + 1) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check_eq("b2b_dones", 32'(n_done - nd), 32'd2);

        // Reset in the middle of RUN aborts the operation with no done pulse.
        nd = n_done;
        run_op(8'hC3, 8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_sum", 32'(sum), 32'd0);
        check_eq("midrst_c_out", 32'(c_out), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check_eq("midrst_no_done", 32'(n_done - nd), 32'd0);
        run_op(8'h5A, 8'h3C, 1'b0); drain();

        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
